// File: rtl/comm_resp_fmt.sv
// Response formatter: turns one captured result record into a fixed ASCII line, one byte per TX handshake.
// Latency: first byte valid one cycle after capture; back-to-back acceptance gives one byte per cycle.
// Backpressure: tx_ready low stalls with tx_data held; rsp_ready is low for the whole line.

package comm_resp_pkg;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;

    localparam logic [1:0] RSP_READ   = 2'd0;
    localparam logic [1:0] RSP_HMSEL  = 2'd1;
    localparam logic [1:0] RSP_DECERR = 2'd2;
    localparam logic [1:0] RSP_AHBERR = 2'd3;

    // Strings are stored reversed so that byte 0 (bits [7:0]) is the first character.
    localparam logic [79:0] STR_READ   = {32'h0, "ATADRH"};
    localparam logic [79:0] STR_HMSEL  = {40'h0, "LESMH"};
    localparam logic [79:0] STR_DECERR = "RRE_EDOCED";
    localparam logic [79:0] STR_AHBERR = {24'h0, "RRE_BHA"};
    localparam logic [79:0] STR_HADDR  = {40'h0, "RDDAH"};

    function automatic logic [7:0] num_to_ascii(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) r = 8'h30 + {4'h0, n};
        else           r = 8'h37 + {4'h0, n};
        return r;
    endfunction

    function automatic logic [7:0] str_char(input logic [79:0] s, input logic [3:0] i);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 10; k++) begin
            if (i == 4'(k)) r = s[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [3:0] nibble(input logic [31:0] v, input logic [3:0] i);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < 8; k++) begin
            if (i == 4'(k)) r = v[4*k +: 4];
        end
        return r;
    endfunction

endpackage

module comm_resp_fmt
    import comm_resp_pkg::*;
#(
    parameter int HEX_DIGITS = 8,
    parameter bit EOL_CRLF   = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [1:0]  rsp_type,
    input  logic [31:0] rsp_data,
    input  logic [31:0] rsp_addr,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LABEL, S_SPC, S_ALBL, S_EQ, S_HEX, S_CR, S_LF
    } state_t;

    localparam logic [3:0] HEX_TOP = 4'(HEX_DIGITS - 1);

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [1:0]  cap_type;
    logic [31:0] cap_val;
    logic        accept;
    logic        capture;
    logic        is_err;
    logic [3:0]  label_last;
    logic [3:0]  hex_first;
    logic [79:0] label_str;

    assign rsp_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign capture   = rsp_valid && rsp_ready;
    assign accept    = tx_valid && tx_ready;
    assign is_err    = (cap_type == RSP_DECERR) || (cap_type == RSP_AHBERR);
    assign hex_first = (cap_type == RSP_HMSEL) ? 4'd0 : HEX_TOP;

    always_comb begin
        label_str  = STR_READ;
        label_last = 4'd5;
        case (cap_type)
            RSP_READ:   begin label_str = STR_READ;   label_last = 4'd5; end
            RSP_HMSEL:  begin label_str = STR_HMSEL;  label_last = 4'd4; end
            RSP_DECERR: begin label_str = STR_DECERR; label_last = 4'd9; end
            default:    begin label_str = STR_AHBERR; label_last = 4'd6; end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            idx      <= 4'd0;
            cap_type <= 2'd0;
            cap_val  <= 32'h0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (capture) begin
                cap_type <= rsp_type;
                // Only the field that the line will print is kept.
                case (rsp_type)
                    RSP_READ:  cap_val <= rsp_data;
                    RSP_HMSEL: cap_val <= {28'h0, rsp_data[3:0]};
                    default:   cap_val <= rsp_addr;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (capture) begin
                    state_nxt = S_LABEL;
                    idx_nxt   = 4'd0;
                end
            end
            S_LABEL: begin
                if (accept) begin
                    if (idx == label_last) begin
                        idx_nxt   = 4'd0;
                        state_nxt = is_err ? S_SPC : S_EQ;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            S_SPC: begin
                if (accept) begin
                    state_nxt = S_ALBL;
                    idx_nxt   = 4'd0;
                end
            end
            S_ALBL: begin
                if (accept) begin
                    if (idx == 4'd4) begin
                        state_nxt = S_EQ;
                        idx_nxt   = 4'd0;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            S_EQ: begin
                if (accept) begin
                    state_nxt = S_HEX;
                    idx_nxt   = hex_first;
                end
            end
            S_HEX: begin
                // Digit index counts down so the most significant kept nibble goes first.
                if (accept) begin
                    if (idx == 4'd0) begin
                        state_nxt = EOL_CRLF ? S_CR : S_LF;
                    end else begin
                        idx_nxt = idx - 4'd1;
                    end
                end
            end
            S_CR: begin
                if (accept) state_nxt = S_LF;
            end
            S_LF: begin
                if (accept) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        tx_valid = (state != S_IDLE);
        tx_data  = 8'h00;
        case (state)
            S_LABEL: tx_data = str_char(label_str, idx);
            S_SPC:   tx_data = ASCII_SPACE;
            S_ALBL:  tx_data = str_char(STR_HADDR, idx);
            S_EQ:    tx_data = ASCII_EQ;
            S_HEX:   tx_data = num_to_ascii(nibble(cap_val, idx));
            S_CR:    tx_data = ASCII_CR;
            S_LF:    tx_data = ASCII_LF;
            default: tx_data = 8'h00;
        endcase
    end

`ifdef RTL_DEBUG
    always @(posedge HCLK) begin
        if (HRESETn && state == S_LF && accept)
            $display("comm_resp_fmt: line done type=%0d value=%08h", cap_type, cap_val);
    end
`endif

endmodule

// File: tb/tb_comm_resp_fmt.sv
// Bench for comm_resp_fmt: directed records, scoreboard of expected ASCII bytes checked at each TX handshake.
// Two instances: default (8 digits, CRLF) and a 4-digit LF-only variant.

module tb_comm_resp_fmt;

    logic        HCLK;
    logic        HRESETn;
    logic        rsp_valid, rsp_ready, tx_valid, tx_ready, busy;
    logic [1:0]  rsp_type;
    logic [31:0] rsp_data, rsp_addr;
    logic [7:0]  tx_data;

    logic        rsp_valid_b, rsp_ready_b, tx_valid_b, tx_ready_b, busy_b;
    logic [1:0]  rsp_type_b;
    logic [31:0] rsp_data_b, rsp_addr_b;
    logic [7:0]  tx_data_b;

    int n_assert = 0;
    int n_fail   = 0;
    int n_acc0   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    comm_resp_fmt dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy)
    );

    comm_resp_fmt #(.HEX_DIGITS(4), .EOL_CRLF(1'b0)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_type(rsp_type_b),
        .rsp_data(rsp_data_b), .rsp_addr(rsp_addr_b),
        .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b), .busy(busy_b)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_str(input int w, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (w == 0) q0.push_back(s[i]);
            else        q1.push_back(s[i]);
        end
    endtask

    task automatic push_hex(input int w, input logic [31:0] v, input int n);
        logic [3:0] d;
        logic [7:0] c;
        for (int i = n - 1; i >= 0; i--) begin
            d = v[4*i +: 4];
            c = (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h41 + {4'h0, d} - 8'd10);
            if (w == 0) q0.push_back(c);
            else        q1.push_back(c);
        end
    endtask

    // Scoreboard checker for the default instance, including stall stability.
    logic       stall_prev = 1'b0;
    logic [7:0] held = 8'h00;
    always @(negedge HCLK) begin
        logic [7:0] e;
        if (HRESETn) begin
            chk("busy_vs_ready", {31'h0, busy}, {31'h0, ~rsp_ready});
            if (stall_prev && tx_valid) chk("stall_hold", {24'h0, tx_data}, {24'h0, held});
            if (tx_valid && tx_ready) begin
                n_acc0++;
                if (q0.size() == 0) begin
                    chk("stray_byte_qsize", q0.size(), 1);
                end else begin
                    e = q0.pop_front();
                    chk("tx_byte", {24'h0, tx_data}, {24'h0, e});
                end
            end
            stall_prev = tx_valid && !tx_ready;
            held       = tx_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(negedge HCLK) begin
        logic [7:0] e;
        if (HRESETn && tx_valid_b && tx_ready_b) begin
            if (q1.size() == 0) begin
                chk("stray_byte_b_qsize", q1.size(), 1);
            end else begin
                e = q1.pop_front();
                chk("tx_byte_b", {24'h0, tx_data_b}, {24'h0, e});
            end
        end
    end

    // Offer a record, wait for capture, check first byte is up the next cycle.
    task automatic offer(input logic [1:0] t, input logic [31:0] d, input logic [31:0] a,
                         output int waits);
        logic rdy;
        rsp_type  = t;
        rsp_data  = d;
        rsp_addr  = a;
        rsp_valid = 1'b1;
        case (t)
            2'd0: begin push_str(0, "HRDATA="); push_hex(0, d, 8); end
            2'd1: begin push_str(0, "HMSEL="); push_hex(0, d, 1); end
            2'd2: begin push_str(0, "DECODE_ERR HADDR="); push_hex(0, a, 8); end
            default: begin push_str(0, "AHB_ERR HADDR="); push_hex(0, a, 8); end
        endcase
        push_str(0, "\r\n");
        waits = 0;
        do begin
            rdy = rsp_ready;
            @(posedge HCLK); #1;
            waits++;
        end while (!rdy && waits < 400);
        if (!rdy) chk("offer_timeout", 0, 1);
        rsp_valid = 1'b0;
        chk("first_byte_valid", {31'h0, tx_valid}, 32'h1);
    endtask

    // mode 0: tx_ready high; 1: random tx_ready; 2: scramble record inputs each cycle.
    task automatic drain(input int mode, output int cyc);
        cyc = 0;
        while (q0.size() != 0 && cyc < 2000) begin
            @(posedge HCLK); #1;
            cyc++;
            if (mode == 1) tx_ready = 1'($urandom_range(0, 1));
            if (mode == 2) begin
                rsp_type = 2'($urandom);
                rsp_data = $urandom;
                rsp_addr = $urandom;
            end
        end
        if (q0.size() != 0) chk("drain_timeout", q0.size(), 0);
        tx_ready = 1'b1;
        chk("ready_after_lf", {31'h0, rsp_ready}, 32'h1);
    endtask

    initial begin
        int w, c;
        HRESETn = 1'b0;
        rsp_valid = 1'b0; rsp_type = 2'd0; rsp_data = 32'h0; rsp_addr = 32'h0;
        tx_ready = 1'b1;
        rsp_valid_b = 1'b0; rsp_type_b = 2'd0; rsp_data_b = 32'h0; rsp_addr_b = 32'h0;
        tx_ready_b = 1'b1;
        #3;
        chk("rst_rsp_ready", {31'h0, rsp_ready}, 32'h1);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_tx_valid_b", {31'h0, tx_valid_b}, 32'h0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // READ at full rate: 17 bytes, back to idle right after LF.
        offer(2'd0, 32'hDEADBEEF, 32'h0, w);
        chk("read_first_char", {24'h0, tx_data}, 32'h48);
        drain(0, c);
        chk("read_cycles", c, 17);

        // DECERR with random backpressure.
        offer(2'd2, 32'h0, 32'h4000_00A0, w);
        drain(1, c);

        // HMSEL single digit.
        offer(2'd1, 32'h0000_000C, 32'h0, w);
        drain(0, c);
        chk("hmsel_cycles", c, 9);

        // AHBERR followed by a READ offered while busy: held off until idle.
        offer(2'd3, 32'h0, 32'hA5A5_0010, w);
        chk("held_off_ready", {31'h0, rsp_ready}, 32'h0);
        offer(2'd0, 32'h0BAD_F00D, 32'h0, w);
        chk("held_off_waits", w, 25);
        drain(0, c);
        chk("read2_cycles", c, 17);

        // Reset after 5 bytes of a READ line.
        c = n_acc0;
        offer(2'd0, 32'h1357_2468, 32'h0, w);
        w = 0;
        while (n_acc0 - c < 5 && w < 100) begin
            @(posedge HCLK); #1;
            w++;
        end
        chk("reset_point_bytes", n_acc0 - c, 5);
        HRESETn = 1'b0;
        #1;
        chk("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("midrst_rsp_ready", {31'h0, rsp_ready}, 32'h1);
        q0.delete();
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        chk("postrst_rsp_ready", {31'h0, rsp_ready}, 32'h1);
        offer(2'd0, 32'h0000_0001, 32'h0, w);
        drain(0, c);
        chk("postrst_cycles", c, 17);

        // AHBERR with record inputs scrambled every cycle after capture.
        offer(2'd3, 32'hFFFF_FFFF, 32'h89AB_CDEF, w);
        drain(2, c);
        rsp_type = 2'd0; rsp_data = 32'h0; rsp_addr = 32'h0;

        // 4-digit LF-only instance: upper bits dropped.
        rsp_type_b = 2'd0; rsp_data_b = 32'h1234_ABCD; rsp_valid_b = 1'b1;
        push_str(1, "HRDATA=");
        push_hex(1, 32'h0000_ABCD, 4);
        push_str(1, "\n");
        chk("b_ready_before", {31'h0, rsp_ready_b}, 32'h1);
        @(posedge HCLK); #1;
        rsp_valid_b = 1'b0;
        chk("b_first_valid", {31'h0, tx_valid_b}, 32'h1);
        c = 0;
        while (q1.size() != 0 && c < 200) begin
            @(posedge HCLK); #1;
            c++;
        end
        chk("b_cycles", c, 12);
        chk("b_ready_after", {31'h0, rsp_ready_b}, 32'h1);

        repeat (3) @(posedge HCLK);
        #1;
        chk("final_q0_empty", q0.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
